// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key constants and helpers for the 4x4 keypad
// decoder. Holds the debounce state enum, the hex key codes, the
// (column,row) -> key code map and a 16-bit popcount used to reject ghosts.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAND    = 2'd1,
        PRESSED = 2'd2
    } dbnc_state_e;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Operator aliases as seen by the game FSM.
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_DIV = 4'hC;
    localparam logic [3:0] KEY_MUL = 4'hD;

    // Physical layout of the Pmod KYPD: column 0..3, row 0..3 -> hex code.
    function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_4;
            4'b00_10: code = KEY_7;
            4'b00_11: code = KEY_0;
            4'b01_00: code = KEY_2;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_8;
            4'b01_11: code = KEY_F;
            4'b10_00: code = KEY_3;
            4'b10_01: code = KEY_6;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_E;
            4'b11_00: code = KEY_A;
            4'b11_01: code = KEY_B;
            4'b11_10: code = KEY_C;
            4'b11_11: code = KEY_D;
            default:  code = KEY_0;
        endcase
        return code;
    endfunction

    // Number of set bits in a 16-bit pressed vector.
    function automatic logic [4:0] popcount16(input logic [15:0] vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: decoded key bus from the keypad decoder to the game controller.
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle strobe on each accepted press
//   key_down  : high while the accepted key is held
// master = keypad_decoder (drives), slave = consumer (game FSM).
interface keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (output key_code, output key_valid, output key_down);
    modport slave  (input  key_code, input  key_valid, input  key_down);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: drives the keypad columns, synchronizes the rows and builds a
// per-scan pressed vector. On the last sample of column 3 (scan_end) it
// reports the single pressed key, or no key when zero or several keys are
// down (ghost rejection).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   row       : raw active-low rows from the pins
//   col       : active-low one-hot column drive
//   scan_end  : high on the sample cycle of column 3
//   raw_hit   : scan_end with exactly one key pressed in the scan
//   raw_key   : code of that key (meaningful with raw_hit)
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       scan_end,
    output logic       raw_hit,
    output logic [3:0] raw_key
);

    localparam int DW = $clog2(SCAN_CYCLES);

    logic [3:0]    row_meta_r;
    logic [3:0]    row_sync_r;
    logic [DW-1:0] dwell_r;
    logic [1:0]    col_idx_r;
    logic [3:0]    col_r;
    logic [15:0]   pressed_r;

    logic          sample_s;
    logic          scan_end_s;
    logic [15:0]   vec_s;
    logic [4:0]    hit_cnt_s;
    logic [3:0]    hit_idx_s;

    assign sample_s   = (dwell_r == DW'(SCAN_CYCLES - 1));
    assign scan_end_s = sample_s && (col_idx_r == 2'd3);

    // Merge the current column's sample into the scan vector and locate the hit.
    always_comb begin
        vec_s = pressed_r;
        vec_s[{col_idx_r, 2'b00} +: 4] = pressed_r[{col_idx_r, 2'b00} +: 4] | ~row_sync_r;
        hit_cnt_s = popcount16(vec_s);
        hit_idx_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            hit_idx_s = vec_s[i] ? 4'(i) : hit_idx_s;
        end
    end

    // Row synchronizer, dwell/column counters and pressed-vector accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
            dwell_r    <= '0;
            col_idx_r  <= 2'd0;
            col_r      <= 4'b1110;
            pressed_r  <= 16'h0000;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
            if (sample_s) begin
                dwell_r   <= '0;
                col_idx_r <= col_idx_r + 2'd1;
                // Rotating the active-low one-hot keeps col == ~(1 << col_idx).
                col_r     <= {col_r[2:0], col_r[3]};
                pressed_r <= scan_end_s ? 16'h0000 : vec_s;
            end else begin
                dwell_r   <= dwell_r + DW'(1);
            end
        end
    end

    assign col      = col_r;
    assign scan_end = scan_end_s;
    assign raw_hit  = scan_end_s && (hit_cnt_s == 5'd1);
    assign raw_key  = key_map(hit_idx_s[3:2], hit_idx_s[1:0]);

endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: top level. Scans a 4x4 keypad through keypad_scan and
// debounces the per-scan result so each physical press yields exactly one
// key_valid strobe with its key_code.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   row      : raw active-low keypad rows (asynchronous)
//   col      : active-low one-hot column drive
//   key_bus  : keypad_if master (key_code, key_valid, key_down)
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    keypad_if.master   key_bus
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic          scan_end_s;
    logic          raw_hit_s;
    logic [3:0]    raw_key_s;

    dbnc_state_e   state_r, state_nx;
    logic [3:0]    cand_r, cand_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [CW-1:0] rel_r, rel_nx;
    logic [CW-1:0] cnt_inc_s, rel_inc_s;
    logic [3:0]    key_code_r, key_code_nx;
    logic          key_valid_r, key_valid_nx;
    logic          key_down_r;

    keypad_scan #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .scan_end (scan_end_s),
        .raw_hit  (raw_hit_s),
        .raw_key  (raw_key_s)
    );

    assign cnt_inc_s = cnt_r + CW'(1);
    assign rel_inc_s = rel_r + CW'(1);

    // Debounce next-state logic; only advances on scan end.
    always_comb begin
        state_nx     = state_r;
        cand_nx      = cand_r;
        cnt_nx       = cnt_r;
        rel_nx       = rel_r;
        key_code_nx  = key_code_r;
        key_valid_nx = 1'b0;
        if (scan_end_s) begin
            case (state_r)
                IDLE: begin
                    if (raw_hit_s) begin
                        cand_nx = raw_key_s;
                        cnt_nx  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nx     = PRESSED;
                            rel_nx       = '0;
                            key_code_nx  = raw_key_s;
                            key_valid_nx = 1'b1;
                        end else begin
                            state_nx = CAND;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
                CAND: begin
                    if (raw_hit_s && (raw_key_s == cand_r)) begin
                        cnt_nx = cnt_inc_s;
                        if (cnt_inc_s == CW'(DEBOUNCE_SCANS)) begin
                            state_nx     = PRESSED;
                            rel_nx       = '0;
                            key_code_nx  = cand_r;
                            key_valid_nx = 1'b1;
                        end else begin
                            state_nx = CAND;
                        end
                    end else if (raw_hit_s) begin
                        // A different single key restarts qualification.
                        cand_nx = raw_key_s;
                        cnt_nx  = CW'(1);
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                PRESSED: begin
                    if (!raw_hit_s) begin
                        if (rel_inc_s == CW'(DEBOUNCE_SCANS)) begin
                            state_nx = IDLE;
                            rel_nx   = '0;
                            cnt_nx   = '0;
                        end else begin
                            rel_nx = rel_inc_s;
                        end
                    end else begin
                        // Any key (even a different one) just holds the press.
                        rel_nx = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    rel_nx   = '0;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Debounce state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cand_r      <= 4'h0;
            cnt_r       <= '0;
            rel_r       <= '0;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cand_r      <= cand_nx;
            cnt_r       <= cnt_nx;
            rel_r       <= rel_nx;
            key_code_r  <= key_code_nx;
            key_valid_r <= key_valid_nx;
            key_down_r  <= (state_nx == PRESSED);
        end
    end

    assign key_bus.key_code  = key_code_r;
    assign key_bus.key_valid = key_valid_r;
    assign key_bus.key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: directed self-checking bench for keypad_decoder with
// SCAN_CYCLES=4, DEBOUNCE_SCANS=3. A keypad model pulls row[r] low when the
// key at (active column, r) is pressed; keys[c*4+r] marks pressed keys.
// All stimulus changes happen on scan boundaries (16-cycle grid after reset).
module tb_keypad_decoder;

    localparam int SC = 4;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [15:0] keys = 16'h0000;

    keypad_if key_bus ();

    keypad_decoder #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row     (row),
        .col     (col),
        .key_bus (key_bus)
    );

    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c*4 + r]) row[r] = 1'b0;
                end
            end
        end
    end

    // Pulse monitor, sampled on the falling edge.
    int         pulse_count = 0;
    int         consec_count = 0;
    logic [3:0] pulse_code = 4'h0;
    logic       prev_valid = 1'b0;
    always @(negedge clk) begin
        if (key_bus.key_valid) begin
            pulse_count = pulse_count + 1;
            pulse_code  = key_bus.key_code;
            if (prev_valid) consec_count = consec_count + 1;
        end
        prev_valid = key_bus.key_valid;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scans(input int n);
        cycles(16 * n);
    endtask

    // Key bit positions (column*4 + row).
    localparam int K1 = 0;   // col0 row0
    localparam int K5 = 5;   // col1 row1
    localparam int K2 = 4;   // col1 row0
    localparam int K3 = 8;   // col2 row0
    localparam int KA = 12;  // col3 row0
    localparam int KD = 15;  // col3 row3

    initial begin
        int         base;
        logic [3:0] exp_col;

        // Reset and idle scanning.
        cycles(3);
        rst = 1'b0;
        check_eq("rst_col", col, 4'b1110);
        check_eq("rst_valid", key_bus.key_valid, 1'b0);
        check_eq("rst_code", key_bus.key_code, 4'h0);
        check_eq("rst_down", key_bus.key_down, 1'b0);
        base = pulse_count;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i % 4));
            check_eq("col_seq", col, exp_col);
            cycles(SC);
        end
        scans(9);
        check_eq("idle_pulses", pulse_count - base, 0);
        check_eq("idle_code", key_bus.key_code, 4'h0);
        check_eq("idle_down", key_bus.key_down, 1'b0);

        // Hold '1': exact pulse cycle, then no repeat while held.
        base = pulse_count;
        keys = 16'h0000; keys[K1] = 1'b1;
        scans(2);
        cycles(15);
        check_eq("k1_early", key_bus.key_valid, 1'b0);
        cycles(1);
        check_eq("k1_pulse", key_bus.key_valid, 1'b1);
        check_eq("k1_code", key_bus.key_code, 4'h1);
        cycles(1);
        check_eq("k1_one_cycle", key_bus.key_valid, 1'b0);
        cycles(15);
        scans(2);
        check_eq("k1_pulses", pulse_count - base, 1);
        check_eq("k1_down", key_bus.key_down, 1'b1);
        check_eq("k1_pcode", pulse_code, 4'h1);
        keys = 16'h0000;
        scans(2);
        check_eq("k1_down_hold", key_bus.key_down, 1'b1);
        scans(1);
        check_eq("k1_released", key_bus.key_down, 1'b0);

        // Bouncy '5' then a clean hold.
        base = pulse_count;
        keys[K5] = 1'b1; scans(1);
        keys = 16'h0000; scans(1);
        keys[K5] = 1'b1; scans(2);
        keys = 16'h0000; scans(1);
        check_eq("k5_bounce", pulse_count - base, 0);
        keys[K5] = 1'b1; scans(4);
        check_eq("k5_pulses", pulse_count - base, 1);
        check_eq("k5_code", key_bus.key_code, 4'h5);
        keys = 16'h0000; scans(3);

        // '2'+'3' ghost, then '2' alone.
        base = pulse_count;
        keys[K2] = 1'b1; keys[K3] = 1'b1; scans(5);
        check_eq("ghost_pulses", pulse_count - base, 0);
        check_eq("ghost_down", key_bus.key_down, 1'b0);
        keys[K3] = 1'b0; scans(4);
        check_eq("k2_pulses", pulse_count - base, 1);
        check_eq("k2_code", key_bus.key_code, 4'h2);
        keys = 16'h0000; scans(3);

        // 'A': short release does not end the press; full release does.
        base = pulse_count;
        keys[KA] = 1'b1; scans(4);
        check_eq("ka_pulses", pulse_count - base, 1);
        check_eq("ka_code", key_bus.key_code, 4'hA);
        keys = 16'h0000; scans(2);
        keys[KA] = 1'b1; scans(1);
        check_eq("ka_repress", pulse_count - base, 1);
        check_eq("ka_down_held", key_bus.key_down, 1'b1);
        keys = 16'h0000; scans(3);
        check_eq("ka_down_rel", key_bus.key_down, 1'b0);
        keys[KA] = 1'b1; scans(4);
        check_eq("ka_second", pulse_count - base, 2);
        check_eq("ka_pcode", pulse_code, 4'hA);
        keys = 16'h0000; scans(3);

        // 'D' accepted, reset while held, re-qualifies.
        keys[KD] = 1'b1; scans(4);
        check_eq("kd_code", key_bus.key_code, 4'hD);
        check_eq("kd_down", key_bus.key_down, 1'b1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_eq("mrst_col", col, 4'b1110);
        check_eq("mrst_valid", key_bus.key_valid, 1'b0);
        check_eq("mrst_code", key_bus.key_code, 4'h0);
        check_eq("mrst_down", key_bus.key_down, 1'b0);
        base = pulse_count;
        scans(3);
        check_eq("kd_again_valid", key_bus.key_valid, 1'b1);
        check_eq("kd_again_code", key_bus.key_code, 4'hD);
        scans(1);
        check_eq("kd_again_pulses", pulse_count - base, 1);
        keys = 16'h0000; scans(3);

        check_eq("no_back_to_back", consec_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
